// File: rtl/coeff_load_responder.sv
// Responder for the FIR coefficient-load handshake: latches a load, holds modwait through a
// WR_CYCLES-long write, then commits into a 4-entry bank. Optional order check: COEFF_SEQ_CHECK_EN.
//
// state  | meaning
// IDLE   | waiting for load_coeff
// BUSY   | write in progress, cnt_q counting down to zero
// COMMIT | bank[idx_q] takes data_q this cycle
module coeff_load_responder #(
    parameter int DATA_W    = 16,
    parameter int WR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              load_coeff,
    input  logic [1:0]        coefficient_num,
    input  logic [DATA_W-1:0] coeff_data,
    input  logic              err_clr,
    input  logic [1:0]        rd_sel,
    output logic              modwait,
    output logic [DATA_W-1:0] fir_coeff,
    output logic              set_done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WR_CYCLES - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [1:0]          idx_q, idx_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   bank_q [4];
`ifdef COEFF_SEQ_CHECK_EN
    logic [1:0]          exp_idx_q, exp_idx_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        err_d   = err_q;
`ifdef COEFF_SEQ_CHECK_EN
        exp_idx_d = exp_idx_q;
`endif
        // clear first so any violation detected below in the same cycle overrides it
        if (err_clr) err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_coeff) begin
                    idx_d   = coefficient_num;
                    data_d  = coeff_data;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
`ifdef COEFF_SEQ_CHECK_EN
                    if (coefficient_num != exp_idx_q) err_d = 1'b1;
`endif
                end
            end
            BUSY: begin
                if (load_coeff) err_d = 1'b1;
                if (cnt_q == 4'd0) state_d = COMMIT;
                else               cnt_d   = cnt_q - 4'd1;
            end
            COMMIT: begin
                if (load_coeff) err_d = 1'b1;
                state_d = IDLE;
`ifdef COEFF_SEQ_CHECK_EN
                exp_idx_d = idx_q + 2'd1;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
`ifdef COEFF_SEQ_CHECK_EN
            exp_idx_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            err_q   <= err_d;
`ifdef COEFF_SEQ_CHECK_EN
            exp_idx_q <= exp_idx_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            for (int i = 0; i < 4; i++) bank_q[i] <= '0;
        end else if (state_q == COMMIT) begin
            bank_q[idx_q] <= data_q;
        end
    end

    assign modwait   = (state_q != IDLE);
    assign set_done  = (state_q == COMMIT) && (idx_q == 2'd3);
    assign err       = err_q;
    assign fir_coeff = bank_q[rd_sel];

endmodule

// File: tb/tb_coeff_load_responder.sv
// Bench for coeff_load_responder: directed scenarios plus a randomized run checked against a
// timestamp-based model (accepted loads, write windows and commit times).
module tb_coeff_load_responder;
    localparam int DATA_W = 16;
    localparam int WR     = 2;

    logic              clk;
    logic              n_reset;
    logic              load_coeff;
    logic [1:0]        coefficient_num;
    logic [DATA_W-1:0] coeff_data;
    logic              err_clr;
    logic [1:0]        rd_sel;
    logic              modwait;
    logic [DATA_W-1:0] fir_coeff;
    logic              set_done;
    logic              err;

    int checks = 0;
    int errors = 0;

    coeff_load_responder #(.DATA_W(DATA_W), .WR_CYCLES(WR)) dut (
        .clk             (clk),
        .n_reset         (n_reset),
        .load_coeff      (load_coeff),
        .coefficient_num (coefficient_num),
        .coeff_data      (coeff_data),
        .err_clr         (err_clr),
        .rd_sel          (rd_sel),
        .modwait         (modwait),
        .fir_coeff       (fir_coeff),
        .set_done        (set_done),
        .err             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a write accepted at cycle a occupies cycles a+1..a+WR+1 and is visible at a+WR+2.
    int                m_t, m_acc;
    bit                m_pend;
    logic [1:0]        m_idx, m_exp;
    logic [DATA_W-1:0] m_data;
    logic [DATA_W-1:0] m_bank [4];
    bit                m_err;
    bit                e_busy, e_done;

    task automatic m_reset();
        m_t = 0; m_acc = 0; m_pend = 0; m_idx = 0; m_exp = 0; m_data = 0; m_err = 0;
        for (int i = 0; i < 4; i++) m_bank[i] = '0;
    endtask

    task automatic m_pre();
        if (m_pend && m_t >= m_acc + WR + 2) begin
            m_bank[m_idx] = m_data;
            m_exp  = m_idx + 2'd1;
            m_pend = 0;
        end
        e_busy = m_pend;
        e_done = m_pend && (m_t == m_acc + WR + 1) && (m_idx == 2'd3);
    endtask

    task automatic m_post(input bit ld, input logic [1:0] ix, input logic [DATA_W-1:0] d, input bit clr);
        bit set_e;
        set_e = 0;
        if (ld) begin
            if (e_busy) set_e = 1;
            else begin
                m_pend = 1; m_acc = m_t; m_idx = ix; m_data = d;
`ifdef COEFF_SEQ_CHECK_EN
                if (ix != m_exp) set_e = 1;
`endif
            end
        end
        if (clr) m_err = 0;
        if (set_e) m_err = 1;
        m_t++;
    endtask

    task automatic drive(input bit ld, input logic [1:0] ix, input logic [DATA_W-1:0] d,
                         input bit clr, input logic [1:0] rs);
        m_pre();
        load_coeff = ld; coefficient_num = ix; coeff_data = d; err_clr = clr; rd_sel = rs;
        #2;
    endtask

    task automatic advance();
        m_post(load_coeff, coefficient_num, coeff_data, err_clr);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        n_reset = 0; load_coeff = 0; coefficient_num = 0; coeff_data = 0; err_clr = 0; rd_sel = 0;
        @(posedge clk); #1;
        n_reset = 1;
        m_reset();
    endtask

    // Idle cycles until modwait drops; returns 1 if it never did.
    task automatic wait_idle(output bit timeout);
        timeout = 1;
        for (int k = 0; k < 40; k++) begin
            drive(0, 0, 0, 0, 0);
            if (!modwait) begin timeout = 0; break; end
            advance();
        end
    endtask

    task automatic test_reset();
        do_reset();
        drive(0, 0, 0, 0, 0);
        checks++; if (modwait !== 1'b0) begin errors++; $display("FAIL reset_modwait: got %b exp 0", modwait); end
        checks++; if (set_done !== 1'b0) begin errors++; $display("FAIL reset_set_done: got %b exp 0", set_done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", err); end
        for (int r = 0; r < 4; r++) begin
            rd_sel = 2'(r); #1;
            checks++; if (fir_coeff !== '0) begin errors++; $display("FAIL reset_bank%0d: got %h exp 0", r, fir_coeff); end
        end
        advance();
    endtask

    task automatic test_single_load();
        do_reset();
        drive(1, 2'd1, 16'h1234, 0, 2'd1);
        checks++; if (modwait !== 1'b0) begin errors++; $display("FAIL single_modwait_c0: got %b exp 0", modwait); end
        advance();
        for (int c = 1; c <= WR + 1; c++) begin
            drive(0, 0, 0, 0, 2'd1);
            checks++; if (modwait !== 1'b1) begin errors++; $display("FAIL single_modwait_c%0d: got %b exp 1", c, modwait); end
            checks++; if (fir_coeff !== 16'h0000) begin errors++; $display("FAIL single_old_c%0d: got %h exp 0000", c, fir_coeff); end
            advance();
        end
        drive(0, 0, 0, 0, 2'd1);
        checks++; if (modwait !== 1'b0) begin errors++; $display("FAIL single_modwait_fall: got %b exp 0", modwait); end
        checks++; if (fir_coeff !== 16'h1234) begin errors++; $display("FAIL single_new: got %h exp 1234", fir_coeff); end
        for (int r = 0; r < 4; r++) begin
            if (r == 1) continue;
            rd_sel = 2'(r); #1;
            checks++; if (fir_coeff !== 16'h0000) begin errors++; $display("FAIL single_other%0d: got %h exp 0000", r, fir_coeff); end
        end
        advance();
    endtask

    task automatic test_initiator();
        int done_cnt, done_idx;
        bit to;
        logic [DATA_W-1:0] v;
        done_cnt = 0; done_idx = -1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            v = 16'(16'h0011 * (i + 1));
            drive(1, 2'(i), v, 0, 0);
            advance();
            to = 1;
            for (int k = 0; k < 40; k++) begin
                drive(0, 0, 0, 0, 0);
                checks++; if (set_done !== e_done) begin errors++; $display("FAIL init_set_done: got %b exp %b", set_done, e_done); end
                if (set_done) begin done_cnt++; done_idx = i; end
                if (!modwait) begin to = 0; break; end
                advance();
            end
            checks++; if (to) begin errors++; $display("FAIL init_timeout: modwait stuck high at load %0d", i); end
        end
        for (int r = 0; r < 4; r++) begin
            rd_sel = 2'(r); #1;
            checks++; if (fir_coeff !== 16'(16'h0011 * (r + 1))) begin errors++;
                $display("FAIL init_bank%0d: got %h exp %h", r, fir_coeff, 16'(16'h0011 * (r + 1))); end
        end
        checks++; if (done_cnt != 1 || done_idx != 3) begin errors++;
            $display("FAIL init_done_pulses: got count %0d idx %0d exp count 1 idx 3", done_cnt, done_idx); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL init_err: got %b exp 0", err); end
        advance();
    endtask

    task automatic test_overrun();
        bit to;
        logic [DATA_W-1:0] a, b, c;
        a = 16'($urandom); b = ~a; c = 16'($urandom);
        do_reset();
        drive(1, 2'd0, a, 0, 0); advance();
        drive(0, 0, 0, 0, 0);    advance();
        drive(1, 2'd0, b, 0, 0);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovr_err_before: got %b exp 0", err); end
        advance();
        drive(0, 0, 0, 0, 0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovr_err_set: got %b exp 1", err); end
        advance();
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL ovr_timeout: modwait stuck high"); end
        rd_sel = 2'd0; #1;
        checks++; if (fir_coeff !== a) begin errors++; $display("FAIL ovr_bank_kept: got %h exp %h", fir_coeff, a); end
        drive(0, 0, 0, 1, 0); advance();
        drive(0, 0, 0, 0, 0);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovr_err_clr: got %b exp 0", err); end
        drive(1, 2'd1, c, 0, 1); advance();
        drive(1, 2'd2, a, 1, 1); advance();
        drive(0, 0, 0, 0, 1);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovr_set_wins: got %b exp 1", err); end
        advance();
        wait_idle(to);
        rd_sel = 2'd1; #1;
        checks++; if (fir_coeff !== c) begin errors++; $display("FAIL ovr_bank1: got %h exp %h", fir_coeff, c); end
        rd_sel = 2'd2; #1;
        checks++; if (fir_coeff !== 16'h0000) begin errors++; $display("FAIL ovr_bank2_untouched: got %h exp 0000", fir_coeff); end
        advance();
    endtask

    task automatic test_seq_check();
        bit to;
        bit exp_err;
`ifdef COEFF_SEQ_CHECK_EN
        exp_err = 1;
`else
        exp_err = 0;
`endif
        do_reset();
        drive(1, 2'd2, 16'hBEEF, 0, 2'd2); advance();
        wait_idle(to);
        rd_sel = 2'd2; #1;
        checks++; if (fir_coeff !== 16'hBEEF) begin errors++; $display("FAIL seq_bank2: got %h exp beef", fir_coeff); end
        checks++; if (err !== exp_err) begin errors++; $display("FAIL seq_err: got %b exp %b", err, exp_err); end
        advance();
    endtask

    task automatic test_reset_mid();
        bit to;
        logic [DATA_W-1:0] x, y;
        x = 16'($urandom) | 16'h0001; y = 16'($urandom) | 16'h8000;
        do_reset();
        drive(1, 2'd0, x, 0, 0); advance();
        drive(0, 0, 0, 0, 0);    advance();
        n_reset = 0;
        drive(0, 0, 0, 0, 0);    advance();
        n_reset = 1;
        m_reset();
        drive(0, 0, 0, 0, 0);
        checks++; if (modwait !== 1'b0) begin errors++; $display("FAIL rstmid_modwait: got %b exp 0", modwait); end
        checks++; if (fir_coeff !== 16'h0000) begin errors++; $display("FAIL rstmid_bank0: got %h exp 0000", fir_coeff); end
        for (int c = 0; c <= WR + 1; c++) begin drive(0, 0, 0, 0, 0); advance(); end
        drive(0, 0, 0, 0, 0);
        checks++; if (fir_coeff !== 16'h0000) begin errors++; $display("FAIL rstmid_no_late_commit: got %h exp 0000", fir_coeff); end
        drive(1, 2'd0, y, 0, 0); advance();
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL rstmid_timeout: modwait stuck high"); end
        checks++; if (fir_coeff !== y) begin errors++; $display("FAIL rstmid_next_load: got %h exp %h", fir_coeff, y); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rstmid_err: got %b exp 0", err); end
        advance();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            automatic bit ld  = ($urandom_range(0, 2) == 0);
            automatic bit clr = ($urandom_range(0, 7) == 0);
            drive(ld, 2'($urandom), 16'($urandom), clr, 2'($urandom));
            checks++; if (modwait !== e_busy) begin errors++; $display("FAIL rnd_modwait t=%0d: got %b exp %b", m_t, modwait, e_busy); end
            checks++; if (set_done !== e_done) begin errors++; $display("FAIL rnd_set_done t=%0d: got %b exp %b", m_t, set_done, e_done); end
            checks++; if (fir_coeff !== m_bank[rd_sel]) begin errors++;
                $display("FAIL rnd_fir t=%0d sel=%0d: got %h exp %h", m_t, rd_sel, fir_coeff, m_bank[rd_sel]); end
            checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err t=%0d: got %b exp %b", m_t, err, m_err); end
            advance();
        end
    endtask

    initial begin
        n_reset = 0; load_coeff = 0; coefficient_num = 0; coeff_data = 0; err_clr = 0; rd_sel = 0;
        m_reset();
        #2;
        test_reset();
        test_single_load();
        test_initiator();
        test_overrun();
        test_seq_check();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
